// File: rtl/run_detect_ctrl_pkg.sv
// Shared definitions for the run detector: one-hot state indices/codes and defaults.
package run_detect_ctrl_pkg;

  localparam int S_IDLE = 0;
  localparam int S_RUN1 = 1;
  localparam int S_HIT1 = 2;
  localparam int S_RUN0 = 3;
  localparam int S_HIT0 = 4;
  localparam int S_LOCK = 5;

  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_RUN1 = 6'b000010;
  localparam logic [5:0] ST_HIT1 = 6'b000100;
  localparam logic [5:0] ST_RUN0 = 6'b001000;
  localparam logic [5:0] ST_HIT0 = 6'b010000;
  localparam logic [5:0] ST_LOCK = 6'b100000;

  // IDLE is stored inverted so an all-zero register decodes as IDLE.
  localparam logic [5:0] IDLE_INV = 6'b000001;

  localparam int RUN_LEN_DEF  = 4;
  localparam int MAX_HITS_DEF = 3;

  function automatic logic is_onehot(input logic [5:0] s);
    return (s != 6'd0) && ((s & (s - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/run_detect_ctrl_dff_sync_rst.sv
// n-bit register with synchronous active-low reset to zero.
module dff_sync_rst #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) q <= '0;
    else         q <= d;
  end

endmodule

// File: rtl/run_detect_ctrl.sv
// One-hot controller detecting RUN_LEN identical bits on w (sampled when en=1),
// counting hits and optionally locking after MAX_HITS detections.
module run_detect_ctrl
  import run_detect_ctrl_pkg::*;
#(
  parameter int RUN_LEN  = RUN_LEN_DEF,
  parameter int CNT_W    = 4,
  parameter int HIT_W    = 8,
  parameter int MAX_HITS = MAX_HITS_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             w,
  input  logic             clr,
  output logic             z,
  output logic             hit_pulse,
  output logic             locked,
  output logic [5:0]       state,
  output logic [CNT_W-1:0] run_cnt,
  output logic [HIT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] RL     = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RL_M1  = CNT_W'(RUN_LEN - 1);
  localparam logic [HIT_W-1:0] MAXH   = HIT_W'(MAX_HITS);
  localparam bit               LOCK_EN = (MAX_HITS != 0);

  logic [5:0]       q_state, nst;
  logic [CNT_W-1:0] run_nxt;
  logic [HIT_W-1:0] hit_nxt, hit_inc;
  logic             pulse_nxt;
  logic             pol1, in_run, same;

  dff_sync_rst #(.N(6)) u_state (
    .clk    (clk),
    .resetn (resetn),
    .d      (nst ^ IDLE_INV),
    .q      (q_state)
  );

  assign state = q_state ^ IDLE_INV;

  assign pol1    = state[S_RUN1] | state[S_HIT1];
  assign in_run  = state[S_RUN1] | state[S_RUN0];
  assign same    = pol1 ? w : ~w;
  assign hit_inc = (&hit_cnt) ? hit_cnt : hit_cnt + 1'b1;

  always_comb begin
    nst       = state;
    run_nxt   = run_cnt;
    hit_nxt   = hit_cnt;
    pulse_nxt = 1'b0;
    if (clr) begin
      nst     = ST_IDLE;
      run_nxt = '0;
      hit_nxt = '0;
    end else if (!is_onehot(state)) begin
      nst     = ST_IDLE;
      run_nxt = '0;
    end else if (state[S_LOCK] || !en) begin
      // LOCK and en=0 both hold everything
    end else if (state[S_IDLE] || !same) begin
      // first bit, or a polarity change, starts a new run
      nst     = w ? ST_RUN1 : ST_RUN0;
      run_nxt = CNT_W'(1);
    end else if (in_run) begin
      if (run_cnt == RL_M1) begin
        run_nxt   = RL;
        pulse_nxt = 1'b1;
        hit_nxt   = hit_inc;
        if (LOCK_EN && hit_inc == MAXH) nst = ST_LOCK;
        else                            nst = pol1 ? ST_HIT1 : ST_HIT0;
      end else begin
        run_nxt = run_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_cnt   <= '0;
      hit_cnt   <= '0;
      hit_pulse <= 1'b0;
    end else begin
      run_cnt   <= run_nxt;
      hit_cnt   <= hit_nxt;
      hit_pulse <= pulse_nxt;
    end
  end

  assign z      = state[S_HIT1] | state[S_HIT0];
  assign locked = state[S_LOCK];

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Directed bench for run_detect_ctrl with RUN_LEN=4, MAX_HITS=3.
module tb_run_detect_ctrl;

  logic       clk = 1'b0;
  logic       resetn, en, w, clr;
  logic       z, hit_pulse, locked;
  logic [5:0] state;
  logic [3:0] run_cnt;
  logic [7:0] hit_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] IDLE = 6'b000001, RUN1 = 6'b000010, HIT1 = 6'b000100,
                         RUN0 = 6'b001000, HIT0 = 6'b010000, LOCK = 6'b100000;

  run_detect_ctrl #(.RUN_LEN(4), .CNT_W(4), .HIT_W(8), .MAX_HITS(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .w         (w),
    .clr       (clr),
    .z         (z),
    .hit_pulse (hit_pulse),
    .locked    (locked),
    .state     (state),
    .run_cnt   (run_cnt),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic b, input logic c);
    resetn = r; en = e; w = b; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // state, z, pulse, locked, run_cnt, hit_cnt in one go
  task automatic chk_all(input string tag, input logic [5:0] s, input logic zz,
                         input logic p, input logic l, input logic [3:0] rc,
                         input logic [7:0] hc);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".z"}, 32'(z), 32'(zz));
    chk({tag, ".pulse"}, 32'(hit_pulse), 32'(p));
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".run_cnt"}, 32'(run_cnt), 32'(rc));
    chk({tag, ".hit_cnt"}, 32'(hit_cnt), 32'(hc));
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; w = 1'b0; clr = 1'b0;
    #2;
    // 1. reset with w toggling
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    chk_all("reset", IDLE, 0, 0, 0, 4'd0, 8'd0);

    // 2. five 1s
    step(1, 1, 1, 0); chk_all("t2e1", RUN1, 0, 0, 0, 4'd1, 8'd0);
    step(1, 1, 1, 0); chk_all("t2e2", RUN1, 0, 0, 0, 4'd2, 8'd0);
    step(1, 1, 1, 0); chk_all("t2e3", RUN1, 0, 0, 0, 4'd3, 8'd0);
    step(1, 1, 1, 0); chk_all("t2e4", HIT1, 1, 1, 0, 4'd4, 8'd1);
    step(1, 1, 1, 0); chk_all("t2e5", HIT1, 1, 0, 0, 4'd4, 8'd1);

    // 3. 1,1,1 then four 0s
    step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    chk_all("t3ones", HIT1, 1, 0, 0, 4'd4, 8'd1);
    step(1, 1, 0, 0); chk_all("t3z1", RUN0, 0, 0, 0, 4'd1, 8'd1);
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk_all("t3z3", RUN0, 0, 0, 0, 4'd3, 8'd1);
    step(1, 1, 0, 0); chk_all("t3z4", HIT0, 1, 1, 0, 4'd4, 8'd2);
    step(1, 0, 1, 0); chk_all("t3hold", HIT0, 1, 0, 0, 4'd4, 8'd2);

    step(1, 0, 0, 1); chk_all("clr1", IDLE, 0, 0, 0, 4'd0, 8'd0);

    // 4. run split by en=0 gap
    step(1, 1, 1, 0); step(1, 1, 1, 0);
    chk_all("t4pre", RUN1, 0, 0, 0, 4'd2, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      chk_all("t4gap", RUN1, 0, 0, 0, 4'd2, 8'd0);
    end
    step(1, 1, 1, 0); chk_all("t4b3", RUN1, 0, 0, 0, 4'd3, 8'd0);
    step(1, 1, 1, 0); chk_all("t4b4", HIT1, 1, 1, 0, 4'd4, 8'd1);

    step(1, 1, 1, 1); chk_all("clr2", IDLE, 0, 0, 0, 4'd0, 8'd0);

    // 5. three hits -> LOCK
    repeat (4) step(1, 1, 1, 0);
    chk_all("t5h1", HIT1, 1, 1, 0, 4'd4, 8'd1);
    repeat (4) step(1, 1, 0, 0);
    chk_all("t5h2", HIT0, 1, 1, 0, 4'd4, 8'd2);
    repeat (4) step(1, 1, 1, 0);
    chk_all("t5lock", LOCK, 0, 1, 1, 4'd4, 8'd3);
    for (int i = 0; i < 10; i++) begin
      step(1, 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
      chk_all("t5rand", LOCK, 0, 0, 1, 4'd4, 8'd3);
    end
    step(1, 0, 0, 1); chk_all("t5clr", IDLE, 0, 0, 0, 4'd0, 8'd0);

    // 6. clr / reset abort a run about to hit
    repeat (3) step(1, 1, 1, 0);
    chk_all("t6pre", RUN1, 0, 0, 0, 4'd3, 8'd0);
    step(1, 1, 1, 1); chk_all("t6clr", IDLE, 0, 0, 0, 4'd0, 8'd0);
    repeat (3) step(1, 1, 1, 0);
    chk_all("t6pre2", RUN1, 0, 0, 0, 4'd3, 8'd0);
    step(0, 1, 1, 0); chk_all("t6rst", IDLE, 0, 0, 0, 4'd0, 8'd0);
    step(1, 1, 0, 0); chk_all("t6after", RUN0, 0, 0, 0, 4'd1, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
